// File: rtl/knn_pkg.sv
// knn_pkg: shared defaults, class-count helper and FSM state encoding for the
// k-nearest-neighbour vote block.
package knn_pkg;

  localparam int unsigned LDefault     = 4;   // log2 of vector length
  localparam int unsigned WDefault     = 16;  // distance width
  localparam int unsigned TypeWDefault = 3;   // class-label width

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StArgmax,
    StDone
  } knn_state_e;

  function automatic int unsigned num_classes(input int unsigned type_w);
    return 32'd1 << type_w;
  endfunction

endpackage

// File: rtl/knn_vote_argmax.sv
// knn_vote_argmax: sequential argmax over per-class vote counters, one class per
// cycle, with ties broken towards the class whose first member has the lower rank.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i           one-cycle pulse; class 0 is evaluated in the same cycle
//   votes_i           vote count per class (held stable during the pass)
//   first_rank_i      rank of the first member of each class (N when absent)
//   best_class_o      running winner including the class evaluated this cycle
//   best_votes_o      vote count of best_class_o
//   done_o            high in the cycle the last class is evaluated; best_* are final
module knn_vote_argmax import knn_pkg::*; #(
  parameter int unsigned TYPE_W = TypeWDefault,
  parameter int unsigned K_W    = LDefault + 1,
  parameter int unsigned N      = 1 << LDefault
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [K_W-1:0]    votes_i      [num_classes(TYPE_W)],
  input  logic [K_W-1:0]    first_rank_i [num_classes(TYPE_W)],
  output logic [TYPE_W-1:0] best_class_o,
  output logic [K_W-1:0]    best_votes_o,
  output logic              done_o
);

  localparam int unsigned NumClasses = num_classes(TYPE_W);

  logic              busy_q;
  logic [TYPE_W-1:0] idx_q;
  logic [TYPE_W-1:0] best_class_q;
  logic [K_W-1:0]    best_votes_q;
  logic [K_W-1:0]    best_rank_q;

  logic              active;
  logic              take;
  logic [TYPE_W-1:0] cur;
  logic [TYPE_W-1:0] base_class;
  logic [K_W-1:0]    base_votes;
  logic [K_W-1:0]    base_rank;
  logic [K_W-1:0]    cand_votes;
  logic [K_W-1:0]    cand_rank;
  logic [TYPE_W-1:0] next_class;
  logic [K_W-1:0]    next_votes;
  logic [K_W-1:0]    next_rank;

  always_comb begin
    active = start_i | busy_q;
    // On start the running best is replaced by an empty candidate so class 0
    // competes against "no votes, rank N".
    cur        = start_i ? '0 : idx_q;
    base_class = start_i ? '0 : best_class_q;
    base_votes = start_i ? '0 : best_votes_q;
    base_rank  = start_i ? K_W'(N) : best_rank_q;
    cand_votes = votes_i[cur];
    cand_rank  = first_rank_i[cur];
    // Zero-vote classes never win, even against an empty running best.
    take = (cand_votes != '0) &&
           ((cand_votes > base_votes) ||
            ((cand_votes == base_votes) && (cand_rank < base_rank)));
    next_class = take ? cur        : base_class;
    next_votes = take ? cand_votes : base_votes;
    next_rank  = take ? cand_rank  : base_rank;
    done_o       = active && (cur == TYPE_W'(NumClasses - 1));
    best_class_o = next_class;
    best_votes_o = next_votes;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q       <= 1'b0;
      idx_q        <= '0;
      best_class_q <= '0;
      best_votes_q <= '0;
      best_rank_q  <= '0;
    end else if (active) begin
      busy_q       <= !done_o;
      idx_q        <= cur + TYPE_W'(1);
      best_class_q <= next_class;
      best_votes_q <= next_votes;
      best_rank_q  <= next_rank;
    end
  end

endmodule

// File: rtl/knn_vote.sv
// knn_vote: k-nearest-neighbour majority vote over an ascending-sorted
// distance/label vector. Counts the first k_eff labels (one per cycle), then runs
// an argmax over all classes and reports the winner for one cycle.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   in_valid_i       sorted vector present (no back-pressure upstream)
//   in_i             sorted distances, entry i at [W*i +: W]
//   in_type_i        class labels, entry i at [TYPE_W*i +: TYPE_W]
//   k_i              neighbour count, sampled on accept (0 -> 1, >N -> N)
//   in_ready_o       high only while idle
//   out_valid_o      one-cycle result pulse
//   out_class_o      winning class (held until the next result)
//   out_votes_o      votes of the winning class
//   out_min_dist_o   distance of the nearest entry
//   drop_err_o       one-cycle pulse the cycle after a vector arrives while busy
module knn_vote import knn_pkg::*; #(
  parameter int unsigned L      = LDefault,
  parameter int unsigned W      = WDefault,
  parameter int unsigned TYPE_W = TypeWDefault,
  parameter int unsigned K_W    = L + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  input  logic [W*(1<<L)-1:0]      in_i,
  input  logic [TYPE_W*(1<<L)-1:0] in_type_i,
  input  logic [K_W-1:0]           k_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  output logic [TYPE_W-1:0]        out_class_o,
  output logic [K_W-1:0]           out_votes_o,
  output logic [W-1:0]             out_min_dist_o,
  output logic                     drop_err_o
);

  localparam int unsigned N          = 1 << L;
  localparam int unsigned NumClasses = num_classes(TYPE_W);

  knn_state_e              state_q;
  logic [TYPE_W*N-1:0]     type_q;
  logic [W-1:0]            dist0_q;
  logic [K_W-1:0]          k_eff_q;
  logic [L-1:0]            rank_q;
  logic [K_W-1:0]          votes_q      [NumClasses];
  logic [K_W-1:0]          first_rank_q [NumClasses];
  logic                    argmax_start_q;

  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [TYPE_W-1:0]       out_class_q;
  logic [K_W-1:0]          out_votes_q;
  logic [W-1:0]            out_min_dist_q;
  logic                    drop_err_q;

  logic [K_W-1:0]          k_eff_d;
  logic [TYPE_W-1:0]       cur_type;
  logic                    last_rank;
  logic [TYPE_W-1:0]       am_class;
  logic [K_W-1:0]          am_votes;
  logic                    am_done;

  // Only the nearest distance is reported; the rest of the vector is not needed.
  logic unused_dist;
  assign unused_dist = ^in_i[W*N-1:W];

  always_comb begin
    if (k_i == '0) begin
      k_eff_d = K_W'(1);
    end else if (k_i > K_W'(N)) begin
      k_eff_d = K_W'(N);
    end else begin
      k_eff_d = k_i;
    end
    cur_type  = type_q[int'(rank_q)*TYPE_W +: TYPE_W];
    last_rank = (K_W'(rank_q) + K_W'(1)) == k_eff_q;
  end

  knn_vote_argmax #(
    .TYPE_W (TYPE_W),
    .K_W    (K_W),
    .N      (N)
  ) u_argmax (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (argmax_start_q),
    .votes_i      (votes_q),
    .first_rank_i (first_rank_q),
    .best_class_o (am_class),
    .best_votes_o (am_votes),
    .done_o       (am_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      type_q         <= '0;
      dist0_q        <= '0;
      k_eff_q        <= '0;
      rank_q         <= '0;
      argmax_start_q <= 1'b0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_class_q    <= '0;
      out_votes_q    <= '0;
      out_min_dist_q <= '0;
      drop_err_q     <= 1'b0;
      for (int c = 0; c < int'(NumClasses); c++) begin
        votes_q[c]      <= '0;
        first_rank_q[c] <= '0;
      end
    end else begin
      out_valid_q    <= 1'b0;
      argmax_start_q <= 1'b0;
      drop_err_q     <= in_valid_i && !in_ready_q;
      unique case (state_q)
        StIdle: begin
          if (in_valid_i && in_ready_q) begin
            type_q     <= in_type_i;
            dist0_q    <= in_i[W-1:0];
            k_eff_q    <= k_eff_d;
            rank_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StCount;
            for (int c = 0; c < int'(NumClasses); c++) begin
              votes_q[c]      <= '0;
              first_rank_q[c] <= K_W'(N);
            end
          end
        end
        StCount: begin
          votes_q[cur_type] <= votes_q[cur_type] + K_W'(1);
          if (votes_q[cur_type] == '0) begin
            first_rank_q[cur_type] <= K_W'(rank_q);
          end
          rank_q <= rank_q + L'(1);
          if (last_rank) begin
            argmax_start_q <= 1'b1;
            state_q        <= StArgmax;
          end
        end
        StArgmax: begin
          // The argmax output is final in the cycle it evaluates the last class.
          if (am_done) begin
            out_class_q    <= am_class;
            out_votes_q    <= am_votes;
            out_min_dist_q <= dist0_q;
            out_valid_q    <= 1'b1;
            state_q        <= StDone;
          end
        end
        StDone: begin
          in_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign out_class_o    = out_class_q;
  assign out_votes_o    = out_votes_q;
  assign out_min_dist_o = out_min_dist_q;
  assign drop_err_o     = drop_err_q;

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed and randomized checks of knn_vote against a behavioural
// k-NN vote model (count labels, take the max, break ties by earliest occurrence).
module tb_knn_vote;

  localparam int L      = 4;
  localparam int W      = 16;
  localparam int TYPE_W = 3;
  localparam int K_W    = L + 1;
  localparam int N      = 1 << L;
  localparam int NC     = 1 << TYPE_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic [W*N-1:0]        in_v = '0;
  logic [TYPE_W*N-1:0]   in_type = '0;
  logic [K_W-1:0]        k = '0;
  logic                  in_ready;
  logic                  out_valid;
  logic [TYPE_W-1:0]     out_class;
  logic [K_W-1:0]        out_votes;
  logic [W-1:0]          out_min_dist;
  logic                  drop_err;

  knn_vote #(
    .L      (L),
    .W      (W),
    .TYPE_W (TYPE_W),
    .K_W    (K_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_i           (in_v),
    .in_type_i      (in_type),
    .k_i            (k),
    .in_ready_o     (in_ready),
    .out_valid_o    (out_valid),
    .out_class_o    (out_class),
    .out_votes_o    (out_votes),
    .out_min_dist_o (out_min_dist),
    .drop_err_o     (drop_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ovalid_cnt = 0;
  int drop_cnt   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) ovalid_cnt++;
    if (drop_err === 1'b1) drop_cnt++;
  end

  // Stimulus and expectation
  int tys_g [N];
  int ds_g  [N];
  int kk_g;
  int exp_cls, exp_votes, exp_keff, exp_dist;
  int acc_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rand_vector(input int kk);
    for (int i = 0; i < N; i++) begin
      tys_g[i] = $urandom_range(NC - 1, 0);
      ds_g[i]  = (i == 0) ? $urandom_range(200, 1) : ds_g[i-1] + $urandom_range(40, 0);
    end
    kk_g = kk;
  endtask

  // Majority over the first k_eff labels; on equal counts the label that appears
  // earliest in the sorted list (i.e. the closer neighbour) wins.
  task automatic compute_expect();
    int cnt [NC];
    int maxv;
    exp_keff = (kk_g == 0) ? 1 : ((kk_g > N) ? N : kk_g);
    for (int c = 0; c < NC; c++) cnt[c] = 0;
    for (int i = 0; i < exp_keff; i++) cnt[tys_g[i]]++;
    maxv = 0;
    for (int c = 0; c < NC; c++) if (cnt[c] > maxv) maxv = cnt[c];
    exp_cls = -1;
    for (int i = 0; i < exp_keff; i++)
      if (exp_cls < 0 && cnt[tys_g[i]] == maxv) exp_cls = tys_g[i];
    exp_votes = maxv;
    exp_dist  = ds_g[0];
  endtask

  task automatic present();
    for (int i = 0; i < N; i++) begin
      in_type[TYPE_W*i +: TYPE_W] = TYPE_W'(tys_g[i]);
      in_v[W*i +: W]              = W'(ds_g[i]);
    end
    k        = K_W'(kk_g);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  // The accept cycle T is the one closed by the accept edge, so a pulse in
  // cycle T + k_eff + NC + 1 is seen k_eff + NC edges after that edge.
  task automatic expect_result(input string tag);
    int seen;
    seen = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = cyc;
        break;
      end
    end
    check({tag, "_latency"}, 32'(seen - acc_cyc), 32'(exp_keff + NC));
    if (seen >= 0) begin
      check({tag, "_class"}, 32'(out_class), 32'(exp_cls));
      check({tag, "_votes"}, 32'(out_votes), 32'(exp_votes));
      check({tag, "_min_dist"}, 32'(out_min_dist), 32'(exp_dist));
      @(negedge clk);
      check({tag, "_pulse_width"}, 32'(out_valid), 32'd0);
    end
  endtask

  task automatic wait_ready(input string tag);
    int ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_ready"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int d0, v0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);
    check("rst_out_votes", 32'(out_votes), 32'd0);
    check("rst_min_dist", 32'(out_min_dist), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Majority: {2,2,5} with k=3
    rand_vector(3);
    tys_g[0] = 2; tys_g[1] = 2; tys_g[2] = 5;
    compute_expect();
    check("maj_model_class", 32'(exp_cls), 32'd2);
    present();
    expect_result("majority");

    // Tie-break: {1,3,3,1} with k=4, class 1 appears first
    rand_vector(4);
    tys_g[0] = 1; tys_g[1] = 3; tys_g[2] = 3; tys_g[3] = 1;
    compute_expect();
    wait_ready("tie");
    present();
    expect_result("tiebreak");
    check("tiebreak_fixed_class", 32'(out_class), 32'd1);

    // k = 0 clamps to 1
    rand_vector(0);
    compute_expect();
    wait_ready("k0");
    present();
    expect_result("k_zero");

    // k = 20 clamps to N
    rand_vector(20);
    compute_expect();
    wait_ready("k20");
    present();
    expect_result("k_big");

    // Randomized vectors over the full k range
    for (int t = 0; t < 20; t++) begin
      rand_vector($urandom_range(31, 0));
      compute_expect();
      wait_ready("rnd");
      present();
      expect_result("random");
    end

    // Overlap: a second vector 3 cycles into the first is dropped
    rand_vector(5);
    compute_expect();
    wait_ready("ovl");
    d0 = drop_cnt;
    present();
    repeat (2) @(posedge clk);
    #1;
    check("overlap_ready_low", 32'(in_ready), 32'd0);
    in_type  = TYPE_W*N'({$urandom, $urandom});
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    expect_result("overlap");
    check("overlap_drop_count", 32'(drop_cnt - d0), 32'd1);
    v0 = ovalid_cnt;
    repeat (30) @(negedge clk);
    check("overlap_no_second", 32'(ovalid_cnt - v0), 32'd0);

    // Reset during rank 2 aborts the vector
    rand_vector(8);
    wait_ready("rstmid");
    present();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_out_class", 32'(out_class), 32'd0);
    check("rstmid_out_votes", 32'(out_votes), 32'd0);
    check("rstmid_min_dist", 32'(out_min_dist), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    v0 = ovalid_cnt;
    repeat (30) @(negedge clk);
    check("rstmid_no_result", 32'(ovalid_cnt - v0), 32'd0);
    rand_vector(2);
    tys_g[0] = 4; tys_g[1] = 4;
    compute_expect();
    wait_ready("postrst");
    present();
    expect_result("post_reset");

    // Back-to-back with k=1
    rand_vector(1);
    compute_expect();
    wait_ready("b2b_a");
    present();
    expect_result("b2b_a");
    rand_vector(1);
    compute_expect();
    wait_ready("b2b_b");
    present();
    expect_result("b2b_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
